// File: rtl/bl_order_gen_multi_if.sv
// Control strobes and emitted baseline tuple of the X-engine order generator.
// Widths derive from the same parameters as the generator instance.
interface bl_order_gen_multi_if #(
  parameter int unsigned N_ANTS     = 8,
  parameter int unsigned N_CHANS    = 1,
  parameter int unsigned ORDER_MODE = 0
);
  localparam int unsigned ANT_BITS  = ($clog2(N_ANTS) < 1) ? 1 : $clog2(N_ANTS);
  localparam int unsigned CHAN_BITS = ($clog2(N_CHANS) < 1) ? 1 : $clog2(N_CHANS);
  localparam int unsigned N_BL      = (ORDER_MODE == 0) ? N_ANTS * (N_ANTS + 1) / 2
                                                         : N_ANTS * (N_ANTS / 2 + 1);
  localparam int unsigned BL_BITS   = ($clog2(N_BL) < 1) ? 1 : $clog2(N_BL);

  logic                 sync;
  logic                 en;
  logic [ANT_BITS-1:0]  ant_a;
  logic [ANT_BITS-1:0]  ant_b;
  logic [CHAN_BITS-1:0] chan;
  logic [BL_BITS-1:0]   bl_idx;
  logic                 first;
  logic                 last;
  logic                 valid;
  logic                 buf_sel;
  logic                 sync_out;

  modport master (
    input  sync, en,
    output ant_a, ant_b, chan, bl_idx, first, last, valid, buf_sel, sync_out
  );

  modport slave (
    output sync, en,
    input  ant_a, ant_b, chan, bl_idx, first, last, valid, buf_sel, sync_out
  );
endinterface

// File: rtl/bl_order_gen_multi.sv
// Baseline-order generator: walks every (ant_a, ant_b, chan) of one accumulation pass,
// triangular or circular-offset order, tagging each tuple with pass parity and flags.
module bl_order_gen_multi #(
  parameter int unsigned N_ANTS     = 8,
  parameter int unsigned N_CHANS    = 1,
  parameter int unsigned ORDER_MODE = 0
) (
  input logic                     clk,
  input logic                     rst,
  bl_order_gen_multi_if.master    bus
);
  localparam int unsigned ANT_BITS  = ($clog2(N_ANTS) < 1) ? 1 : $clog2(N_ANTS);
  localparam int unsigned CHAN_BITS = ($clog2(N_CHANS) < 1) ? 1 : $clog2(N_CHANS);
  localparam int unsigned N_BL      = (ORDER_MODE == 0) ? N_ANTS * (N_ANTS + 1) / 2
                                                         : N_ANTS * (N_ANTS / 2 + 1);
  localparam int unsigned BL_BITS   = ($clog2(N_BL) < 1) ? 1 : $clog2(N_BL);

  localparam logic [ANT_BITS-1:0]  ANT_MAX  = ANT_BITS'(N_ANTS - 1);
  localparam logic [CHAN_BITS-1:0] CHAN_MAX = CHAN_BITS'(N_CHANS - 1);
  localparam logic [BL_BITS-1:0]   BL_MAX   = BL_BITS'(N_BL - 1);

  // Pointer to the next tuple to emit
  logic [ANT_BITS-1:0]  a_q, a_d, b_q, b_d, k_q, k_d;
  logic [CHAN_BITS-1:0] c_q, c_d;
  logic [BL_BITS-1:0]   idx_q, idx_d;
  logic                 par_q, par_d;

  // Registered outputs
  logic [ANT_BITS-1:0]  ant_a_q, ant_a_d, ant_b_q, ant_b_d;
  logic [CHAN_BITS-1:0] chan_q, chan_d;
  logic [BL_BITS-1:0]   bl_idx_q, bl_idx_d;
  logic                 first_q, first_d, last_q, last_d, valid_q, valid_d;
  logic                 buf_sel_q, buf_sel_d, sync_out_q, sync_out_d;

  logic c_last, bl_last;

  assign c_last  = (c_q == CHAN_MAX);
  assign bl_last = (idx_q == BL_MAX);

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    c_d        = c_q;
    idx_d      = idx_q;
    par_d      = par_q;
    ant_a_d    = ant_a_q;
    ant_b_d    = ant_b_q;
    chan_d     = chan_q;
    bl_idx_d   = bl_idx_q;
    first_d    = first_q;
    last_d     = last_q;
    valid_d    = valid_q;
    buf_sel_d  = buf_sel_q;
    sync_out_d = 1'b0;

    if (bus.sync) begin
      a_d        = '0;
      b_d        = '0;
      k_d        = '0;
      c_d        = '0;
      idx_d      = '0;
      par_d      = 1'b0;
      valid_d    = 1'b0;
      sync_out_d = 1'b1;
    end else if (bus.en) begin
      ant_a_d   = a_q;
      ant_b_d   = b_q;
      chan_d    = c_q;
      bl_idx_d  = idx_q;
      first_d   = (idx_q == '0) && (c_q == '0);
      last_d    = bl_last && c_last;
      valid_d   = 1'b1;
      buf_sel_d = par_q;

      if (!c_last) begin
        c_d = c_q + 1'b1;
      end else begin
        c_d = '0;
        if (bl_last) begin
          // Pass wrap: restart at the first tuple with no gap cycle
          a_d   = '0;
          b_d   = '0;
          k_d   = '0;
          idx_d = '0;
          par_d = ~par_q;
        end else begin
          idx_d = idx_q + 1'b1;
          if (ORDER_MODE == 0) begin
            if (b_q == a_q) begin
              a_d = a_q + 1'b1;
              b_d = '0;
            end else begin
              b_d = b_q + 1'b1;
            end
          end else if (a_q == ANT_MAX) begin
            a_d = '0;
            k_d = k_q + 1'b1;
            b_d = k_q + 1'b1;
          end else begin
            a_d = a_q + 1'b1;
            b_d = (b_q == ANT_MAX) ? '0 : b_q + 1'b1;
          end
        end
      end
    end else begin
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      c_q        <= '0;
      idx_q      <= '0;
      par_q      <= 1'b0;
      ant_a_q    <= '0;
      ant_b_q    <= '0;
      chan_q     <= '0;
      bl_idx_q   <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      buf_sel_q  <= 1'b0;
      sync_out_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      c_q        <= c_d;
      idx_q      <= idx_d;
      par_q      <= par_d;
      ant_a_q    <= ant_a_d;
      ant_b_q    <= ant_b_d;
      chan_q     <= chan_d;
      bl_idx_q   <= bl_idx_d;
      first_q    <= first_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      buf_sel_q  <= buf_sel_d;
      sync_out_q <= sync_out_d;
    end
  end

  assign bus.ant_a    = ant_a_q;
  assign bus.ant_b    = ant_b_q;
  assign bus.chan     = chan_q;
  assign bus.bl_idx   = bl_idx_q;
  assign bus.first    = first_q;
  assign bus.last     = last_q;
  assign bus.valid    = valid_q;
  assign bus.buf_sel  = buf_sel_q;
  assign bus.sync_out = sync_out_q;
endmodule

// File: tb/tb_bl_order_gen_multi.sv
// Four generator configurations share one stimulus stream; each is checked every cycle
// against a tuple table built directly from the ordering rules.
module tb_bl_order_gen_multi;
  localparam int NDUT = 4;

  logic clk;
  logic rst;
  logic sync;
  logic en;

  int n_tests = 0;
  int n_fail  = 0;

  bl_order_gen_multi_if #(.N_ANTS(4), .N_CHANS(1), .ORDER_MODE(0)) if0 ();
  bl_order_gen_multi_if #(.N_ANTS(4), .N_CHANS(1), .ORDER_MODE(1)) if1 ();
  bl_order_gen_multi_if #(.N_ANTS(3), .N_CHANS(2), .ORDER_MODE(0)) if2 ();
  bl_order_gen_multi_if #(.N_ANTS(5), .N_CHANS(3), .ORDER_MODE(1)) if3 ();

  assign if0.sync = sync;
  assign if0.en   = en;
  assign if1.sync = sync;
  assign if1.en   = en;
  assign if2.sync = sync;
  assign if2.en   = en;
  assign if3.sync = sync;
  assign if3.en   = en;

  bl_order_gen_multi #(.N_ANTS(4), .N_CHANS(1), .ORDER_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0.master));
  bl_order_gen_multi #(.N_ANTS(4), .N_CHANS(1), .ORDER_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master));
  bl_order_gen_multi #(.N_ANTS(3), .N_CHANS(2), .ORDER_MODE(0)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.master));
  bl_order_gen_multi #(.N_ANTS(5), .N_CHANS(3), .ORDER_MODE(1)) dut3 (
    .clk(clk), .rst(rst), .bus(if3.master));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full tuple sequence of one pass, plus position/parity and expected outputs
  int ta[NDUT][$];
  int tb_[NDUT][$];
  int tc[NDUT][$];
  int ti[NDUT][$];
  int len[NDUT];
  int pos[NDUT];
  int par[NDUT];
  int e_a[NDUT], e_b[NDUT], e_c[NDUT], e_idx[NDUT];
  int e_first[NDUT], e_last[NDUT], e_valid[NDUT], e_buf[NDUT], e_so[NDUT];

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic build(input int d, input int n, input int nc, input int mode);
    int idx;
    idx = 0;
    if (mode == 0) begin
      for (int a = 0; a < n; a++)
        for (int b = 0; b <= a; b++) begin
          for (int c = 0; c < nc; c++) begin
            ta[d].push_back(a); tb_[d].push_back(b); tc[d].push_back(c); ti[d].push_back(idx);
          end
          idx++;
        end
    end else begin
      for (int k = 0; k <= n / 2; k++)
        for (int a = 0; a < n; a++) begin
          for (int c = 0; c < nc; c++) begin
            ta[d].push_back(a); tb_[d].push_back((a + k) % n); tc[d].push_back(c);
            ti[d].push_back(idx);
          end
          idx++;
        end
    end
    len[d] = ta[d].size();
  endtask

  task automatic model_edge(input int d);
    if (rst) begin
      pos[d] = 0; par[d] = 0;
      e_a[d] = 0; e_b[d] = 0; e_c[d] = 0; e_idx[d] = 0;
      e_first[d] = 0; e_last[d] = 0; e_valid[d] = 0; e_buf[d] = 0; e_so[d] = 0;
    end else if (sync) begin
      pos[d] = 0; par[d] = 0;
      e_valid[d] = 0; e_so[d] = 1;
    end else if (en) begin
      e_a[d]     = ta[d][pos[d]];
      e_b[d]     = tb_[d][pos[d]];
      e_c[d]     = tc[d][pos[d]];
      e_idx[d]   = ti[d][pos[d]];
      e_first[d] = (pos[d] == 0);
      e_last[d]  = (pos[d] == len[d] - 1);
      e_valid[d] = 1;
      e_buf[d]   = par[d];
      e_so[d]    = 0;
      pos[d]++;
      if (pos[d] == len[d]) begin
        pos[d] = 0;
        par[d] ^= 1;
      end
    end else begin
      e_valid[d] = 0; e_first[d] = 0; e_last[d] = 0; e_so[d] = 0;
    end
  endtask

  task automatic check_dut(input int d, input int a, input int b, input int c, input int idx,
                           input int fi, input int la, input int va, input int bs, input int so);
    check_val($sformatf("d%0d.ant_a", d), a, e_a[d]);
    check_val($sformatf("d%0d.ant_b", d), b, e_b[d]);
    check_val($sformatf("d%0d.chan", d), c, e_c[d]);
    check_val($sformatf("d%0d.bl_idx", d), idx, e_idx[d]);
    check_val($sformatf("d%0d.first", d), fi, e_first[d]);
    check_val($sformatf("d%0d.last", d), la, e_last[d]);
    check_val($sformatf("d%0d.valid", d), va, e_valid[d]);
    check_val($sformatf("d%0d.buf_sel", d), bs, e_buf[d]);
    check_val($sformatf("d%0d.sync_out", d), so, e_so[d]);
  endtask

  task automatic step(input logic r, input logic s, input logic e);
    @(negedge clk);
    rst  = r;
    sync = s;
    en   = e;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) model_edge(d);
    #1;
    check_dut(0, int'(if0.ant_a), int'(if0.ant_b), int'(if0.chan), int'(if0.bl_idx),
              int'(if0.first), int'(if0.last), int'(if0.valid), int'(if0.buf_sel),
              int'(if0.sync_out));
    check_dut(1, int'(if1.ant_a), int'(if1.ant_b), int'(if1.chan), int'(if1.bl_idx),
              int'(if1.first), int'(if1.last), int'(if1.valid), int'(if1.buf_sel),
              int'(if1.sync_out));
    check_dut(2, int'(if2.ant_a), int'(if2.ant_b), int'(if2.chan), int'(if2.bl_idx),
              int'(if2.first), int'(if2.last), int'(if2.valid), int'(if2.buf_sel),
              int'(if2.sync_out));
    check_dut(3, int'(if3.ant_a), int'(if3.ant_b), int'(if3.chan), int'(if3.bl_idx),
              int'(if3.first), int'(if3.last), int'(if3.valid), int'(if3.buf_sel),
              int'(if3.sync_out));
  endtask

  int e1a[11] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
  int e1b[11] = '{0, 0, 1, 0, 1, 2, 0, 1, 2, 3, 0};

  initial begin
    rst  = 1'b1;
    sync = 1'b0;
    en   = 1'b0;
    build(0, 4, 1, 0);
    build(1, 4, 1, 1);
    build(2, 3, 2, 0);
    build(3, 5, 3, 1);
    check_val("tbl0.len", len[0], 10);
    check_val("tbl1.len", len[1], 12);
    check_val("tbl2.len", len[2], 12);

    step(1, 0, 0);
    step(1, 0, 1);
    step(0, 1, 0);

    // Literal triangular sequence for the 4-antenna instance, including the wrap
    for (int i = 0; i < 11; i++) begin
      step(0, 0, 1);
      check_val("t1.ant_a", int'(if0.ant_a), e1a[i]);
      check_val("t1.ant_b", int'(if0.ant_b), e1b[i]);
      check_val("t1.buf_sel", int'(if0.buf_sel), (i == 10) ? 1 : 0);
    end

    for (int i = 0; i < 40; i++) step(0, 0, 1);

    // en toggling
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 1); step(0, 0, 1); step(0, 0, 0);

    // sync mid-pass together with en, then resume
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(0, 1, 1);
    check_val("t5.valid", int'(if0.valid), 0);
    check_val("t5.sync_out", int'(if0.sync_out), 1);
    step(0, 0, 1);
    check_val("t5.ant_a", int'(if0.ant_a), 0);
    check_val("t5.buf_sel", int'(if0.buf_sel), 0);

    // rst mid-pass
    for (int i = 0; i < 7; i++) step(0, 0, 1);
    step(1, 0, 1);
    check_val("t6.valid", int'(if0.valid), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      logic r, s, e;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, s, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
